alu_result_buffer: RTL and testbench

//  Output buffer stage directly downstream of the 8-bit ALU.

---
 rtl/alu_result_buffer.sv | 89 ++++++++
 tb/tb_alu_result_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Output buffer behind the 8-bit ALU: a small FIFO of {carry,result} entries with
// push/stop handshakes on both sides, a running delivery checksum and a sticky drop flag.
module alu_result_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushin,
  input  logic                     cin,
  input  logic [DW-1:0]            zin,
  output logic                     stopout,
  output logic                     pushout,
  output logic                     cout,
  output logic [DW-1:0]            z,
  input  logic                     stopin,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              sum,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   sum_q, sum_d;
  logic          drop_err_q, drop_err_d;
  logic          accept, deliver;
  logic [EW-1:0] head;

  // Handshake: a transfer happens on an edge where the sender's push is high and the
  // receiver's stop is low; push/data must stay stable while stop holds them off.
  // Both stop and push here come only from registered occupancy, never from stopin.
  assign stopout = (level_q == LW'(DEPTH));
  assign pushout = (level_q != '0);
  assign accept  = pushin & ~stopout;
  assign deliver = pushout & ~stopin;

  assign head      = mem_q[rd_ptr_q];
  assign {cout, z} = pushout ? head : '0;

  assign level    = level_q;
  assign sum      = sum_q;
  assign drop_err = drop_err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    sum_d      = sum_q;
    drop_err_d = drop_err_q | (pushin & stopout);
    if (accept)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (deliver) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      sum_d    = sum_q + 16'(head);
    end
    case ({accept, deliver})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sum_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sum_q      <= sum_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {cin, zin};
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: scoreboard queue model checked every cycle on the falling edge.
module tb_alu_result_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pushin, cin, stopin;
  logic [DW-1:0] zin;
  logic          stopout, pushout, cout, drop_err;
  logic [DW-1:0] z;
  logic [2:0]    level;
  logic [15:0]   sum;

  int checks   = 0;
  int failures = 0;

  logic [DW:0]   exp_q[$];
  logic [15:0]   model_sum;
  logic          model_drop;

  alu_result_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .cin(cin), .zin(zin),
    .stopout(stopout), .pushout(pushout), .cout(cout), .z(z),
    .stopin(stopin), .level(level), .sum(sum), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [DW:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check_eq("level",    32'(level),    32'(exp_q.size()));
    check_eq("pushout",  32'(pushout),  32'(exp_q.size() != 0));
    check_eq("stopout",  32'(stopout),  32'(exp_q.size() == DEPTH));
    check_eq("head",     32'({cout, z}), 32'(head));
    check_eq("sum",      32'(sum),      32'(model_sum));
    check_eq("drop_err", 32'(drop_err), 32'(model_drop));
  endtask

  task automatic drive(input logic p, input logic [DW:0] v, input logic s);
    pushin = p;
    {cin, zin} = v;
    stopin = s;
  endtask

  // Advance one clock: update the model from the inputs now applied, then check after the edge.
  task automatic cycle();
    logic [DW:0] v;
    bit acc, del;
    acc = pushin && (exp_q.size() < DEPTH);
    del = (exp_q.size() != 0) && !stopin;
    if (pushin && exp_q.size() == DEPTH) model_drop = 1'b1;
    if (del) begin
      v = exp_q.pop_front();
      model_sum = model_sum + 16'(v);
    end
    if (acc) exp_q.push_back({cin, zin});
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_sum  = '0;
    model_drop = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    apply_reset();
    check_eq("reset_level", 32'(level), 32'd0);

    // Single pass
    drive(1'b1, {1'b1, 8'hA5}, 1'b0);
    cycle();
    check_eq("single_out", 32'({pushout, cout, z}), 32'({1'b1, 1'b1, 8'hA5}));
    drive(1'b0, '0, 1'b0);
    cycle();
    check_eq("single_sum", 32'(sum), 32'h01A5);
    check_eq("single_lvl", 32'(level), 32'd0);

    // Fill under backpressure, then overflow push
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 9'(i), 1'b1);
      cycle();
    end
    check_eq("fill_level", 32'(level), 32'd4);
    check_eq("fill_stop",  32'(stopout), 32'd1);
    drive(1'b1, 9'h05, 1'b1);
    cycle();
    check_eq("drop_set",   32'(drop_err), 32'd1);
    check_eq("drop_level", 32'(level), 32'd4);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_order", 32'(z), 32'(i));
      drive(1'b0, '0, 1'b0);
      cycle();
    end

    // Full with simultaneous deliver: push is refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'h10 + 9'(i), 1'b1);
      cycle();
    end
    drive(1'b1, 9'h1EE, 1'b0);
    cycle();
    check_eq("full_deliver_lvl", 32'(level), 32'd3);
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    // Steady stream: occupancy stays within 0..1
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 9'($urandom_range(0, 511)), 1'b0);
      cycle();
      check_eq("stream_lvl_le1", 32'(level <= 3'd1), 32'd1);
    end
    drive(1'b0, '0, 1'b0);
    cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0));
      cycle();
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();

    // Asynchronous reset mid-stream at level 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'h30 + 9'(i), 1'b1);
      cycle();
    end
    check_eq("pre_reset_lvl", 32'(level), 32'd3);
    drive(1'b0, '0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_level",   32'(level),    32'd0);
    check_eq("async_rst_pushout", 32'(pushout),  32'd0);
    check_eq("async_rst_sum",     32'(sum),      32'd0);
    check_eq("async_rst_drop",    32'(drop_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    cycle();

    // Checksum wrap: 257 deliveries of 0x1FF -> 257*511 mod 65536 = 0x00FF
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 9'h1FF, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("sum_wrap", 32'(sum), 32'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
